control_unit: RTL and testbench
===============================

# control_unit

Hard-wired Moore sequencer that drives every control input of the processor datapath. It consumes the opcode decoded from IR and the CON flip-flop result. It steps fetch, decode and execute states, one state per clock, and emits the bus-drive, register-enable, memory and ALU strobes the datapath samples on the next rising edge. It is the initiator side of the datapath control interface and replaces testbench-driven control.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, synchronous, active-low
- opcode  in  5  IR[31:27] from datapath IR logic
- CON_out  in  1  branch condition from CON flip-flop
- stop  in  1  halt request, sampled only in T0
- Gra, Grb, Grc, R_enable, Rout, BAout  out  1 each  IR register-select and register in/out strobes
- PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout  out  1 each  bus-drive selects, at most one asserted per state
- enablePC, enableIR, enableMAR, enableMDR, enableY, enableZ, enableHI, enableLO, enableOutPort, enableCON  out  1 each  register load enables
- IncPC, RAM_read, RAM_write  out  1 each  ALU PC+1 select and memory strobes
- MDR_read  out  3  MDR input mux select: 0 = bus, 1 = RAM
- R_enableIn  out  16  direct register enables; only bit 15 is ever driven (jal)
- run  out  1  high while executing; low in RESET and HALT

## Operation
- Opcode map: 00000 ld, 00001 ldi, 00010 st, 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol, 01011 addi, 01100 andi, 01101 ori, 01110 mul, 01111 div, 10000 neg, 10001 not, 10010 br, 10011 jr, 10100 jal, 10101 in, 10110 out, 10111 mfhi, 11000 mflo, 11001 nop, 11010 halt.
- Opcodes 11011 to 11111 behave as nop. The ALU operation comes from the IR opcode inside the datapath, not from this block.
- Outputs decode from the current state only. Every output not listed for a state is 0.
- Fetch:
  - T0: PCout, enableMAR, IncPC, enableZ.
  - T1: ZLowout, enablePC, RAM_read, MDR_read=1, enableMDR.
  - T2: MDRout, enableIR.
  - T2 -> T3 unconditionally. The class dispatch in T3 uses the opcode loaded at the T2 edge.
- Execute (after the last listed state, return to T0):
  - R-type (add..rol):
    - T3 Grb, Rout, enableY
    - T4 Grc, Rout, enableZ
    - T5 ZLowout, Gra, R_enable
  - addi/andi/ori:
    - T3 Grb, Rout, enableY
    - T4 Cout, enableZ
    - T5 ZLowout, Gra, R_enable
  - ldi:
    - T3 Grb, BAout, Rout, enableY
    - T4 Cout, enableZ
    - T5 ZLowout, Gra, R_enable
  - ld:
    - T3 to T4 as ldi
    - T5 ZLowout, enableMAR
    - T6 RAM_read, MDR_read=1, enableMDR
    - T7 MDRout, Gra, R_enable
  - st:
    - T3 to T5 as ld
    - T6 Gra, Rout, MDR_read=0, enableMDR
    - T7 RAM_write
  - mul/div:
    - T3 Gra, Rout, enableY
    - T4 Grb, Rout, enableZ
    - T5 ZLowout, enableLO
    - T6 ZHighout, enableHI
  - neg/not:
    - T3 Grb, Rout, enableZ
    - T4 ZLowout, Gra, R_enable
  - br:
    - T3 Gra, Rout, enableCON
    - T4 PCout, enableY
    - T5 Cout, enableZ
    - T6 ZLowout, and enablePC only if CON_out=1; CON_out is sampled combinationally in T6
  - jr: T3 Gra, Rout, enablePC.
  - jal:
    - T3 PCout, R_enableIn=16'h8000
    - T4 Gra, Rout, enablePC
  - in: T3 InPortout, Gra, R_enable. out: T3 Gra, Rout, enableOutPort.
  - mfhi: T3 HIout, Gra, R_enable. mflo: T3 LOout, Gra, R_enable.
  - nop: T3 with no strobes.
  - halt: T3 -> HALT.
- HALT: all outputs 0, run=0. Only clr low exits HALT.
- stop=1 in T0 aborts fetch: T0 strobes are suppressed and the next state is HALT.

## Timing
- clr low at any edge gives state RESET, overriding every other transition, including mid-instruction.
- In RESET all outputs are 0 and run=0.
- The first edge with clr high moves RESET -> T0 with run=1.
- No RAM_write or register enable may appear between reset and the next T0.
- Instruction latency, T0 inclusive: 6 cycles for R-type, immediate and ldi; 8 for ld and st; 7 for mul/div and br; 5 for neg/not and jal; 4 for jr, in, out, mfhi, mflo and nop.
- Bus-drive selects are one-hot or zero in every state.

## Test plan
- clr low 2 cycles, then high: outputs all 0 during reset. T0 follows one cycle after release with PCout, enableMAR, IncPC and enableZ high.
- opcode=00011 (add): cycles T0..T5 as specified. Gra and R_enable are high only in the 6th cycle, and T0 repeats in the 7th.
- opcode=00010 (st): RAM_write high exactly in cycle 8. Repeat with clr pulsed low in T6: RAM_write never asserts and the next state after reset is T0.
- opcode=10010 (br) with CON_out=1, then CON_out=0: enablePC high in T6 in the first run only, ZLowout high in both runs.
- opcode=01110 (mul): enableLO in T5, enableHI in T6, no R_enable anywhere in the instruction.
- opcode=11010 (halt), and separately stop=1 in T0: run drops to 0 and stays 0 with all outputs 0 for 20 cycles, until clr low.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hard-wired Moore sequencer for the processor datapath.
// Steps RESET -> T0..T2 (fetch) -> T3..T7 (execute) and decodes every
// datapath strobe from the current state and the instruction class.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  opcode,
  input  logic        CON_out,
  input  logic        stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_enable,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        enablePC,
  output logic        enableIR,
  output logic        enableMAR,
  output logic        enableMDR,
  output logic        enableY,
  output logic        enableZ,
  output logic        enableHI,
  output logic        enableLO,
  output logic        enableOutPort,
  output logic        enableCON,
  output logic        IncPC,
  output logic        RAM_read,
  output logic        RAM_write,
  output logic [2:0]  MDR_read,
  output logic [15:0] R_enableIn,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } iclass_t;

  state_t  state_reg;
  iclass_t iclass;
  state_t  last_state;

  // Group opcodes into classes that share one execute micro-sequence.
  always_comb begin
    iclass = C_NOP;
    case (opcode)
      5'b00000: iclass = C_LD;
      5'b00001: iclass = C_LDI;
      5'b00010: iclass = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: iclass = C_RTYPE;
      5'b01011, 5'b01100, 5'b01101:           iclass = C_IMM;
      5'b01110, 5'b01111:                     iclass = C_MULDIV;
      5'b10000, 5'b10001:                     iclass = C_NEGNOT;
      5'b10010: iclass = C_BR;
      5'b10011: iclass = C_JR;
      5'b10100: iclass = C_JAL;
      5'b10101: iclass = C_IN;
      5'b10110: iclass = C_OUT;
      5'b10111: iclass = C_MFHI;
      5'b11000: iclass = C_MFLO;
      5'b11010: iclass = C_HALT;
      default:  iclass = C_NOP;
    endcase
  end

  // Final execute state of each class; reaching it ends the instruction.
  always_comb begin
    last_state = S_T3;
    case (iclass)
      C_RTYPE, C_IMM, C_LDI: last_state = S_T5;
      C_LD, C_ST:            last_state = S_T7;
      C_MULDIV, C_BR:        last_state = S_T6;
      C_NEGNOT, C_JAL:       last_state = S_T4;
      default:               last_state = S_T3;
    endcase
  end

  // Sequencer: reset wins, stop is honoured only in T0, execute runs to the class end.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg <= S_RESET;
    end else begin
      case (state_reg)
        S_RESET: state_reg <= S_T0;
        S_T0:    state_reg <= stop ? S_HALT : S_T1;
        S_T1:    state_reg <= S_T2;
        S_T2:    state_reg <= S_T3;
        S_T3, S_T4, S_T5, S_T6, S_T7: begin
          if (state_reg == last_state)
            state_reg <= (iclass == C_HALT) ? S_HALT : S_T0;
          else
            state_reg <= state_t'(state_reg + 4'd1);
        end
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_RESET;
      endcase
    end
  end

  // Strobe decode from the current state; only br's T6 PC load looks at CON_out.
  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_enable = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
    enablePC = 1'b0; enableIR = 1'b0; enableMAR = 1'b0; enableMDR = 1'b0;
    enableY = 1'b0; enableZ = 1'b0; enableHI = 1'b0; enableLO = 1'b0;
    enableOutPort = 1'b0; enableCON = 1'b0;
    IncPC = 1'b0; RAM_read = 1'b0; RAM_write = 1'b0;
    MDR_read = 3'd0; R_enableIn = 16'h0000;
    run = (state_reg != S_RESET) && (state_reg != S_HALT);
    case (state_reg)
      S_T0: if (!stop) begin PCout = 1'b1; enableMAR = 1'b1; IncPC = 1'b1; enableZ = 1'b1; end
      S_T1: begin ZLowout = 1'b1; enablePC = 1'b1; RAM_read = 1'b1; MDR_read = 3'd1; enableMDR = 1'b1; end
      S_T2: begin MDRout = 1'b1; enableIR = 1'b1; end
      S_T3: begin
        case (iclass)
          C_RTYPE, C_IMM:     begin Grb = 1'b1; Rout = 1'b1; enableY = 1'b1; end
          C_LDI, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Rout = 1'b1; enableY = 1'b1; end
          C_MULDIV:           begin Gra = 1'b1; Rout = 1'b1; enableY = 1'b1; end
          C_NEGNOT:           begin Grb = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
          C_BR:               begin Gra = 1'b1; Rout = 1'b1; enableCON = 1'b1; end
          C_JR:               begin Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1; end
          C_JAL:              begin PCout = 1'b1; R_enableIn = 16'h8000; end
          C_IN:               begin InPortout = 1'b1; Gra = 1'b1; R_enable = 1'b1; end
          C_OUT:              begin Gra = 1'b1; Rout = 1'b1; enableOutPort = 1'b1; end
          C_MFHI:             begin HIout = 1'b1; Gra = 1'b1; R_enable = 1'b1; end
          C_MFLO:             begin LOout = 1'b1; Gra = 1'b1; R_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          C_RTYPE:                   begin Grc = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
          C_IMM, C_LDI, C_LD, C_ST:  begin Cout = 1'b1; enableZ = 1'b1; end
          C_MULDIV:                  begin Grb = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
          C_NEGNOT:                  begin ZLowout = 1'b1; Gra = 1'b1; R_enable = 1'b1; end
          C_BR:                      begin PCout = 1'b1; enableY = 1'b1; end
          C_JAL:                     begin Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_RTYPE, C_IMM, C_LDI: begin ZLowout = 1'b1; Gra = 1'b1; R_enable = 1'b1; end
          C_LD, C_ST:            begin ZLowout = 1'b1; enableMAR = 1'b1; end
          C_MULDIV:              begin ZLowout = 1'b1; enableLO = 1'b1; end
          C_BR:                  begin Cout = 1'b1; enableZ = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_LD:     begin RAM_read = 1'b1; MDR_read = 3'd1; enableMDR = 1'b1; end
          C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDR_read = 3'd0; enableMDR = 1'b1; end
          C_MULDIV: begin ZHighout = 1'b1; enableHI = 1'b1; end
          C_BR:     begin ZLowout = 1'b1; enablePC = CON_out; end
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; R_enable = 1'b1; end
          C_ST:    RAM_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed stimulus for control_unit, checked every cycle
// against a table-driven instruction model plus hand-computed spot checks.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, CON_out, stop;
  logic [4:0]  opcode;
  logic Gra, Grb, Grc, R_enable, Rout, BAout;
  logic PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout;
  logic enablePC, enableIR, enableMAR, enableMDR, enableY, enableZ;
  logic enableHI, enableLO, enableOutPort, enableCON;
  logic IncPC, RAM_read, RAM_write, run;
  logic [2:0]  MDR_read;
  logic [15:0] R_enableIn;

  control_unit dut (
    .clk(clk), .clr(clr), .opcode(opcode), .CON_out(CON_out), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_enable(R_enable), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .ZHighout(ZHighout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .enablePC(enablePC), .enableIR(enableIR), .enableMAR(enableMAR), .enableMDR(enableMDR),
    .enableY(enableY), .enableZ(enableZ), .enableHI(enableHI), .enableLO(enableLO),
    .enableOutPort(enableOutPort), .enableCON(enableCON),
    .IncPC(IncPC), .RAM_read(RAM_read), .RAM_write(RAM_write),
    .MDR_read(MDR_read), .R_enableIn(R_enableIn), .run(run)
  );

  always #5 clk = ~clk;

  // All outputs packed into one vector for comparison.
  logic [46:0] vec;
  assign vec = {R_enableIn, MDR_read, run, RAM_write, RAM_read, IncPC, enableCON,
                enableOutPort, enableLO, enableHI, enableZ, enableY, enableMDR,
                enableMAR, enableIR, enablePC, Cout, InPortout, LOout, HIout,
                ZHighout, ZLowout, MDRout, PCout, BAout, Rout, R_enable, Grc, Grb, Gra};

  localparam logic [46:0] NONE    = '0;
  localparam logic [46:0] M_GRA   = 47'd1 << 0;
  localparam logic [46:0] M_GRB   = 47'd1 << 1;
  localparam logic [46:0] M_GRC   = 47'd1 << 2;
  localparam logic [46:0] M_REN   = 47'd1 << 3;
  localparam logic [46:0] M_ROUT  = 47'd1 << 4;
  localparam logic [46:0] M_BA    = 47'd1 << 5;
  localparam logic [46:0] M_PCOUT = 47'd1 << 6;
  localparam logic [46:0] M_MDROUT= 47'd1 << 7;
  localparam logic [46:0] M_ZLOW  = 47'd1 << 8;
  localparam logic [46:0] M_ZHIGH = 47'd1 << 9;
  localparam logic [46:0] M_HIOUT = 47'd1 << 10;
  localparam logic [46:0] M_LOOUT = 47'd1 << 11;
  localparam logic [46:0] M_INP   = 47'd1 << 12;
  localparam logic [46:0] M_COUT  = 47'd1 << 13;
  localparam logic [46:0] M_PC    = 47'd1 << 14;
  localparam logic [46:0] M_IR    = 47'd1 << 15;
  localparam logic [46:0] M_MAR   = 47'd1 << 16;
  localparam logic [46:0] M_MDR   = 47'd1 << 17;
  localparam logic [46:0] M_Y     = 47'd1 << 18;
  localparam logic [46:0] M_Z     = 47'd1 << 19;
  localparam logic [46:0] M_HI    = 47'd1 << 20;
  localparam logic [46:0] M_LO    = 47'd1 << 21;
  localparam logic [46:0] M_OUTP  = 47'd1 << 22;
  localparam logic [46:0] M_CON   = 47'd1 << 23;
  localparam logic [46:0] M_INC   = 47'd1 << 24;
  localparam logic [46:0] M_RAMRD = 47'd1 << 25;
  localparam logic [46:0] M_RAMWR = 47'd1 << 26;
  localparam logic [46:0] M_RUN   = 47'd1 << 27;
  localparam logic [46:0] M_MDR1  = 47'd1 << 28;
  localparam logic [46:0] M_RIN15 = 47'd1 << 46;
  localparam logic [46:0] T0_VEC  = M_PCOUT | M_MAR | M_INC | M_Z | M_RUN;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [46:0] act, input logic [46:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Execute micro-steps of an instruction (step 0 = T3), straight from the opcode table.
  function automatic logic [46:0] ustep(input logic [4:0] op, input int s, input logic con);
    logic [46:0] t [5];
    t = '{NONE, NONE, NONE, NONE, NONE};
    if (op >= 5'd3 && op <= 5'd10)       t = '{M_GRB|M_ROUT|M_Y, M_GRC|M_ROUT|M_Z, M_ZLOW|M_GRA|M_REN, NONE, NONE};
    else if (op >= 5'd11 && op <= 5'd13) t = '{M_GRB|M_ROUT|M_Y, M_COUT|M_Z, M_ZLOW|M_GRA|M_REN, NONE, NONE};
    else if (op == 5'd1)  t = '{M_GRB|M_BA|M_ROUT|M_Y, M_COUT|M_Z, M_ZLOW|M_GRA|M_REN, NONE, NONE};
    else if (op == 5'd0)  t = '{M_GRB|M_BA|M_ROUT|M_Y, M_COUT|M_Z, M_ZLOW|M_MAR, M_RAMRD|M_MDR1|M_MDR, M_MDROUT|M_GRA|M_REN};
    else if (op == 5'd2)  t = '{M_GRB|M_BA|M_ROUT|M_Y, M_COUT|M_Z, M_ZLOW|M_MAR, M_GRA|M_ROUT|M_MDR, M_RAMWR};
    else if (op == 5'd14 || op == 5'd15) t = '{M_GRA|M_ROUT|M_Y, M_GRB|M_ROUT|M_Z, M_ZLOW|M_LO, M_ZHIGH|M_HI, NONE};
    else if (op == 5'd16 || op == 5'd17) t = '{M_GRB|M_ROUT|M_Z, M_ZLOW|M_GRA|M_REN, NONE, NONE, NONE};
    else if (op == 5'd18) t = '{M_GRA|M_ROUT|M_CON, M_PCOUT|M_Y, M_COUT|M_Z, M_ZLOW|(con ? M_PC : NONE), NONE};
    else if (op == 5'd19) t = '{M_GRA|M_ROUT|M_PC, NONE, NONE, NONE, NONE};
    else if (op == 5'd20) t = '{M_PCOUT|M_RIN15, M_GRA|M_ROUT|M_PC, NONE, NONE, NONE};
    else if (op == 5'd21) t = '{M_INP|M_GRA|M_REN, NONE, NONE, NONE, NONE};
    else if (op == 5'd22) t = '{M_GRA|M_ROUT|M_OUTP, NONE, NONE, NONE, NONE};
    else if (op == 5'd23) t = '{M_HIOUT|M_GRA|M_REN, NONE, NONE, NONE, NONE};
    else if (op == 5'd24) t = '{M_LOOUT|M_GRA|M_REN, NONE, NONE, NONE, NONE};
    return (s >= 0 && s < 5) ? t[s] : NONE;
  endfunction

  // Number of execute cycles per instruction.
  function automatic int nsteps(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd2) return 5;
    if (op >= 5'd1 && op <= 5'd13) return 3;
    if (op == 5'd14 || op == 5'd15 || op == 5'd18) return 4;
    if (op == 5'd16 || op == 5'd17 || op == 5'd20) return 2;
    return 1;
  endfunction

  // Model: mode 0 = reset, 1 = running at cycle k of the instruction (0 = T0), 2 = halted.
  int m_mode = 0;
  int m_k = 0;
  bit m_valid = 1'b0;

  function automatic logic [46:0] model_out(input int mode, input int k, input logic [4:0] op,
                                            input logic con, input logic stp);
    logic [46:0] r;
    if (mode != 1) return NONE;
    r = M_RUN;
    if (k == 0)      r = r | (stp ? NONE : (M_PCOUT | M_MAR | M_INC | M_Z));
    else if (k == 1) r = r | M_ZLOW | M_PC | M_RAMRD | M_MDR1 | M_MDR;
    else if (k == 2) r = r | M_MDROUT | M_IR;
    else             r = r | ustep(op, k - 3, con);
    return r;
  endfunction

  // Advance the model on each rising edge.
  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (!clr) m_mode <= 0;
    else if (m_mode == 0) begin m_mode <= 1; m_k <= 0; end
    else if (m_mode == 1) begin
      if (m_k == 0 && stop) m_mode <= 2;
      else if (m_k >= 3 && m_k == 2 + nsteps(opcode)) begin
        if (opcode == 5'd26) m_mode <= 2;
        else m_k <= 0;
      end else m_k <= m_k + 1;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (m_valid) check("cycle", vec, model_out(m_mode, m_k, opcode, CON_out, stop));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [46:0] trace [8];

  // Run one instruction of n cycles from T0; records each cycle's outputs.
  task automatic run_instr(input logic [4:0] op, input logic con, input int n);
    opcode = op;
    CON_out = con;
    for (int i = 0; i < n; i++) begin
      trace[i] = vec;
      tick();
    end
    $display("instr opcode=%05b con=%0d cycles=%0d", op, con, n);
  endtask

  int lat_tab [32] = '{8,6,8,6,6,6,6,6,6,6,6, 6,6,6, 7,7, 5,5, 7,4,5, 4,4,4,4, 4,4, 4,4,4,4,4};
  logic [46:0] acc;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b0; opcode = 5'd25; CON_out = 1'b0; stop = 1'b0;
    tick(); check("reset0", vec, NONE);
    tick(); check("reset1", vec, NONE);
    clr = 1'b1;
    tick(); check("t0_after_reset", vec, T0_VEC);

    // add
    run_instr(5'd3, 1'b0, 6);
    check("add_c6_gra_ren", trace[5] & (M_GRA | M_REN), M_GRA | M_REN);
    acc = trace[0] | trace[1] | trace[2] | trace[3] | trace[4];
    check("add_c1_5_no_gra_ren", acc & (M_GRA | M_REN), NONE);
    check("add_t0_repeat", vec, T0_VEC);

    // st
    run_instr(5'd2, 1'b0, 8);
    check("st_c8_ramwr", trace[7] & M_RAMWR, M_RAMWR);
    acc = trace[0] | trace[1] | trace[2] | trace[3] | trace[4] | trace[5] | trace[6];
    check("st_c1_7_no_ramwr", acc & M_RAMWR, NONE);

    // st aborted by reset in T6
    opcode = 5'd2;
    acc = NONE;
    for (int i = 0; i < 6; i++) begin acc = acc | vec; tick(); end
    check("st_t6_state", vec, M_GRA | M_ROUT | M_MDR | M_RUN);
    clr = 1'b0;
    tick(); check("st_abort_reset", vec, NONE);
    acc = acc | vec;
    clr = 1'b1;
    tick(); check("st_abort_t0", vec, T0_VEC);
    check("st_abort_no_ramwr", acc & M_RAMWR, NONE);

    // br taken / not taken
    run_instr(5'd18, 1'b1, 7);
    check("br_taken_t6", trace[6] & (M_PC | M_ZLOW), M_PC | M_ZLOW);
    run_instr(5'd18, 1'b0, 7);
    check("br_not_taken_t6", trace[6] & (M_PC | M_ZLOW), M_ZLOW);

    // mul
    run_instr(5'd14, 1'b0, 7);
    check("mul_t5_lo", trace[5] & M_LO, M_LO);
    check("mul_t6_hi", trace[6] & M_HI, M_HI);
    acc = NONE;
    for (int i = 0; i < 7; i++) acc = acc | trace[i];
    check("mul_no_ren", acc & M_REN, NONE);

    // jal drives only bit 15 of the direct enables
    run_instr(5'd20, 1'b0, 5);
    check("jal_t3", trace[3], M_PCOUT | M_RIN15 | M_RUN);

    // latency of every opcode except halt
    for (int o = 0; o < 32; o++) begin
      logic [4:0] op5;
      op5 = 5'(o);
      if (o != 26) begin
        run_instr(op5, op5[0], lat_tab[o]);
        check($sformatf("latency_op%0d", o), vec, T0_VEC);
      end
    end

    // halt instruction
    run_instr(5'd26, 1'b0, 4);
    acc = NONE;
    for (int i = 0; i < 20; i++) begin acc = acc | vec; tick(); end
    check("halt_idle", acc, NONE);
    clr = 1'b0; tick(); check("halt_reset", vec, NONE);
    clr = 1'b1; tick(); check("halt_exit_t0", vec, T0_VEC);

    // stop in T0
    opcode = 5'd3;
    stop = 1'b1;
    #1 check("stop_t0_suppressed", vec, M_RUN);
    tick();
    stop = 1'b0;
    acc = NONE;
    for (int i = 0; i < 20; i++) begin acc = acc | vec; tick(); end
    check("stop_idle", acc, NONE);
    clr = 1'b0; tick();
    clr = 1'b1; tick(); check("stop_exit_t0", vec, T0_VEC);
    run_instr(5'd3, 1'b0, 6);
    check("final_t0", vec, T0_VEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
